comma_aligner: RTL and testbench



---
 rtl/comma_aligner.sv | 175 +++++++++++++++++
 tb/tb_comma_aligner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comma_aligner.sv
// Receive word aligner: finds the 8b/10b comma in a bit-slipped 10-bit stream,
// latches its offset and emits aligned symbols; decoder code errors drive loss of sync.
module comma_aligner #(
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_LIMIT   = 4,
  parameter int GOOD_RUN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  input  logic       dec_valid,
  input  logic       code_err,
  output logic [9:0] dout,
  output logic       dout_valid,
  output logic       comma,
  output logic       locked,
  output logic [3:0] offset
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
  localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);
  localparam logic [7:0] GOOD_N = 8'(GOOD_RUN);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] prev_q, prev_d;
  logic [3:0] offset_q, offset_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [7:0] good_q, good_d;
  logic [9:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       comma_q, comma_d;

  logic [19:0] win;
  logic [9:0]  cand [10];
  logic [9:0]  cand_comma;
  logic        hit;
  logic [3:0]  hit_off;
  logic [9:0]  sel;
  logic        sel_comma;

  function automatic logic is_comma(input logic [9:0] s);
    return (s[9:3] == 7'b0011111) || (s[9:3] == 7'b1100000);
  endfunction

  assign win = {prev_q, rx_data};

  // Scan from the top down so the lowest offset holding a comma wins.
  always_comb begin
    hit     = 1'b0;
    hit_off = 4'd0;
    for (int o = 9; o >= 0; o--) begin
      cand[o]       = win[19-o -: 10];
      cand_comma[o] = is_comma(cand[o]);
      if (cand_comma[o]) begin
        hit     = 1'b1;
        hit_off = 4'(o);
      end
    end
  end

  always_comb begin
    sel       = '0;
    sel_comma = 1'b0;
    for (int o = 0; o < 10; o++) begin
      if (offset_q == 4'(o)) begin
        sel       = cand[o];
        sel_comma = cand_comma[o];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    offset_d     = offset_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    good_d       = good_q;
    dout_d       = dout_q;
    comma_d      = comma_q;
    dout_valid_d = 1'b0;
    if (rx_valid) begin
      prev_d       = rx_data;
      dout_d       = sel;
      comma_d      = sel_comma;
      dout_valid_d = (state_q != ST_HUNT);
      case (state_q)
        ST_HUNT: begin
          if (hit) begin
            offset_d = hit_off;
            cnt_d    = 4'd1;
            state_d  = (LOCK_N == 4'd1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (dec_valid && code_err) begin
            state_d = ST_HUNT;
            cnt_d   = 4'd0;
            err_d   = 4'd0;
            good_d  = 8'd0;
          end else if (sel_comma) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == LOCK_N) state_d = ST_LOCKED;
          end else if (hit) begin
            offset_d = hit_off;
            cnt_d    = 4'd1;
          end
        end
        ST_LOCKED: begin
          if (dec_valid) begin
            if (code_err) begin
              good_d = 8'd0;
              if (err_q + 4'd1 == ERR_N) begin
                state_d = ST_HUNT;
                cnt_d   = 4'd0;
                err_d   = 4'd0;
              end else begin
                err_d = err_q + 4'd1;
              end
            end else if (err_q != 4'd0) begin
              if (good_q + 8'd1 == GOOD_N) begin
                err_d  = err_q - 4'd1;
                good_d = 8'd0;
              end else begin
                good_d = good_q + 8'd1;
              end
            end else if (good_q != GOOD_N) begin
              good_d = good_q + 8'd1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      prev_q       <= '0;
      offset_q     <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      good_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      comma_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      offset_q     <= offset_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      good_q       <= good_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      comma_q      <= comma_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign comma      = comma_q;
  assign locked     = (state_q == ST_LOCKED);
  assign offset     = offset_q;

endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: directed scenarios on a bit-level stream plus a random
// phase, checked against a behavioural model of the alignment rules.
module tb_comma_aligner;
  localparam int LOCK_COMMAS = 3;
  localparam int ERR_LIMIT   = 4;
  localparam int GOOD_RUN    = 4;
  localparam logic [9:0] K285N = 10'b0011111010;
  localparam logic [9:0] K285P = 10'b1100000101;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic       clk = 1'b0;
  logic       rst, rx_valid, dec_valid, code_err;
  logic [9:0] rx_data;
  logic [9:0] dout;
  logic       dout_valid, comma, locked;
  logic [3:0] offset;

  comma_aligner #(.LOCK_COMMAS(LOCK_COMMAS), .ERR_LIMIT(ERR_LIMIT), .GOOD_RUN(GOOD_RUN)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .dec_valid(dec_valid), .code_err(code_err), .dout(dout),
    .dout_valid(dout_valid), .comma(comma), .locked(locked), .offset(offset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_mode, m_off, m_cnt, m_err, m_good;
  logic [9:0]  m_prev, m_dout;
  logic        m_dv, m_comma;
  logic [10:0] exp_q[$];
  bit          bitq[$];
  int          fill_mode = 0;

  function automatic bit is_comma(input logic [9:0] s);
    return (s[9:3] == 7'b0011111) || (s[9:3] == 7'b1100000);
  endfunction

  function automatic logic [9:0] cand_at(input logic [9:0] p, input logic [9:0] r, input int o);
    logic [19:0] w;
    w = {p, r} >> (10 - o);
    return w[9:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [9:0] d, input bit dv, input bit ce);
    int hit;
    logic [9:0] c;
    if (r) begin
      m_mode = M_HUNT; m_prev = '0; m_off = 0; m_cnt = 0; m_err = 0; m_good = 0;
      m_dout = '0; m_dv = 0; m_comma = 0;
      exp_q.delete();
    end else if (!v) begin
      m_dv = 0;
    end else begin
      hit = -1;
      for (int o = 9; o >= 0; o--) if (is_comma(cand_at(m_prev, d, o))) hit = o;
      c = cand_at(m_prev, d, m_off);
      m_dout = c;
      m_comma = is_comma(c);
      m_dv = (m_mode != M_HUNT);
      if (m_dv) exp_q.push_back({m_comma, m_dout});
      case (m_mode)
        M_HUNT: if (hit >= 0) begin
          m_off = hit; m_cnt = 1;
          m_mode = (LOCK_COMMAS == 1) ? M_LOCKED : M_VERIFY;
        end
        M_VERIFY: begin
          if (dv && ce) begin
            m_mode = M_HUNT; m_cnt = 0; m_err = 0; m_good = 0;
          end else if (m_comma) begin
            m_cnt++;
            if (m_cnt == LOCK_COMMAS) m_mode = M_LOCKED;
          end else if (hit >= 0) begin
            m_off = hit; m_cnt = 1;
          end
        end
        default: if (dv) begin
          if (ce) begin
            m_err++; m_good = 0;
            if (m_err == ERR_LIMIT) begin
              m_mode = M_HUNT; m_cnt = 0; m_err = 0; m_good = 0;
            end
          end else if (m_err > 0) begin
            m_good++;
            if (m_good == GOOD_RUN) begin m_err--; m_good = 0; end
          end else if (m_good < GOOD_RUN) begin
            m_good++;
          end
        end
      endcase
      m_prev = d;
    end
  endtask

  task automatic check_outputs();
    logic [10:0] e;
    chk("dout_valid", 16'(dout_valid), 16'(m_dv));
    chk("locked", 16'(locked), 16'(m_mode == M_LOCKED));
    chk("offset", 16'(offset), 16'(m_off));
    if (m_dv) begin
      e = exp_q.pop_front();
      chk("dout", 16'(dout), 16'(e[9:0]));
      chk("comma", 16'(comma), 16'(e[10]));
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [9:0] d, input bit dv, input bit ce);
    rst = r; rx_valid = v; rx_data = d; dec_valid = dv; code_err = ce;
    @(posedge clk);
    model_step(r, v, d, dv, ce);
    #1;
    check_outputs();
  endtask

  task automatic push_bits(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
  endtask

  task automatic next_word(input bit dv, input bit ce);
    logic [9:0] w;
    int sel;
    if (bitq.size() < 10) begin
      sel = (fill_mode == 0) ? 0 : int'($urandom_range(0, 3));
      case (sel)
        1: push_bits(K285P, 10);
        2: push_bits(10'($urandom), 10);
        default: push_bits(K285N, 10);
      endcase
    end
    w = '0;
    for (int i = 0; i < 10; i++) w = {w[8:0], bitq.pop_front()};
    step(1'b0, 1'b1, w, dv, ce);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("rst_dout", 16'(dout), 16'd0);
    chk("rst_comma", 16'(comma), 16'd0);
    rst = 1'b0;
  endtask

  // Restart the bit stream with a K28.5 run slipped so commas sit at offset 3.
  task automatic start_slip3();
    bitq.delete();
    push_bits(K285N, 3);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; dec_valid = 1'b0; code_err = 1'b0;
    do_reset();

    // 1: K28.5 stream slipped by 3 bits locks at offset 3 after the 3rd comma word
    start_slip3();
    repeat (3) next_word(1'b0, 1'b0);
    chk("s1_not_locked", 16'(locked), 16'd0);
    next_word(1'b0, 1'b0);
    chk("s1_locked", 16'(locked), 16'd1);
    chk("s1_offset", 16'(offset), 16'd3);
    chk("s1_dout", 16'(dout), 16'(K285N));
    chk("s1_comma", 16'(comma), 16'd1);
    // commas at another offset while locked must not realign
    push_bits(10'b101, 3);
    repeat (4) next_word(1'b0, 1'b0);
    chk("s1_no_realign", 16'(offset), 16'd3);
    chk("s1_still_locked", 16'(locked), 16'd1);

    // 2: relatch from offset 3 (count 2) to offset 6
    do_reset();
    bitq.delete();
    push_bits(10'b101, 3); push_bits(K285N, 10); push_bits(K285N, 10); push_bits(10'b101, 3);
    repeat (3) next_word(1'b0, 1'b0);
    chk("s2_off3", 16'(offset), 16'd3);
    next_word(1'b0, 1'b0);
    chk("s2_off6", 16'(offset), 16'd6);
    next_word(1'b0, 1'b0);
    chk("s2_not_yet", 16'(locked), 16'd0);
    next_word(1'b0, 1'b0);
    chk("s2_locked", 16'(locked), 16'd1);

    // 3: four consecutive code errors drop lock; dout_valid follows a cycle later
    repeat (3) next_word(1'b1, 1'b1);
    chk("s3_hold", 16'(locked), 16'd1);
    next_word(1'b1, 1'b1);
    chk("s3_unlock", 16'(locked), 16'd0);
    next_word(1'b0, 1'b0);
    chk("s3_dv_drop", 16'(dout_valid), 16'd0);

    // 4: 3 errors, 4 clean, 1 error keeps lock; one more error reaches the limit
    do_reset();
    start_slip3();
    repeat (4) next_word(1'b0, 1'b0);
    repeat (3) next_word(1'b1, 1'b1);
    repeat (4) next_word(1'b1, 1'b0);
    next_word(1'b1, 1'b1);
    chk("s4_locked", 16'(locked), 16'd1);
    next_word(1'b1, 1'b1);
    chk("s4_unlock", 16'(locked), 16'd0);

    // 5: rx_valid toggling; idle cycles carry junk that must be ignored
    do_reset();
    start_slip3();
    for (int i = 0; i < 5; i++) begin
      next_word(1'b0, 1'b0);
      step(1'b0, 1'b0, 10'($urandom), 1'($urandom), 1'($urandom));
    end
    chk("s5_offset", 16'(offset), 16'd3);
    chk("s5_locked", 16'(locked), 16'd1);

    // 6: reset while locked wins over a simultaneous valid word and error
    step(1'b1, 1'b1, K285N, 1'b1, 1'b1);
    chk("s6_dout", 16'(dout), 16'd0);
    chk("s6_locked", 16'(locked), 16'd0);
    chk("s6_offset", 16'(offset), 16'd0);
    repeat (3) next_word(1'b0, 1'b0);
    chk("s6_relock_wait", 16'(locked), 16'd0);
    next_word(1'b0, 1'b0);
    chk("s6_relocked", 16'(locked), 16'd1);

    // random phase: mixed symbols, slips, gaps, errors, occasional reset
    fill_mode = 1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit dv, ce;
      if ($urandom_range(0, 39) == 0) push_bits(10'($urandom), int'($urandom_range(1, 9)));
      dv = ($urandom_range(0, 3) == 0);
      ce = dv && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) step(1'b1, 1'($urandom), 10'($urandom), dv, ce);
      else if ($urandom_range(0, 4) == 0) step(1'b0, 1'b0, 10'($urandom), dv, ce);
      else next_word(dv, ce);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
